wave_nco: RTL and testbench
===========================

WAVE_NCO -- requirements
Module: wave_nco

Interface
REQ-001 width_p, 12, sample width in bits (min 2).
REQ-002 phase_width_p, 24, phase accumulator width in bits (SHALL be >= width_p).
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 reset_ni  input  1  asynchronous, active-low reset.
REQ-005 en_i  input  1  generator enable.
REQ-006 freq_i  input  phase_width_p  phase increment per accepted sample (unsigned).
REQ-007 mode_i  input  2  waveform select (wave_mode_t).
REQ-008 duty_i  input  width_p  square-wave high threshold.
REQ-009 sync_i  input  1  phase restart pulse.
REQ-010 ready_i  input  1  downstream accepts data_o.
REQ-011 valid_o  output  1  data_o holds a valid sample.
REQ-012 data_o  output  width_p  unsigned sample, 0 to 2^width_p-1.

Function
REQ-013 Phase accumulator SHALL wrap modulo 2^phase_width_p; u = phase[phase_width_p-1 -: width_p].
REQ-014 Step condition: en_i && (!valid_o || ready_i); on step, data_o <= shape(u), valid_o <= 1, phase <= phase + freq_i.
REQ-015 When !en_i && ready_i && valid_o: valid_o <= 0, data_o held, phase held.
REQ-016 valid_o && !ready_i: data_o, valid_o, phase SHALL hold (no drop, no advance).
REQ-017 Latency: first valid sample on the clock edge after the first cycle with en_i=1 following reset release; one sample per cycle at full throughput.
REQ-018 Modes: SAW (0) data = u; TRI (1) data = (u[msb] ? ~u : u) << 1, truncated to width_p; SQR (2) data = (u < duty) ? all-ones : 0; OFF (3) data = 0.
REQ-019 Active mode and duty SHALL be shadow registers loaded from mode_i/duty_i only on: step with carry-out of phase addition, sync_i=1, or en_i=0.
REQ-020 freq_i SHALL take effect on the next step (no shadowing).
REQ-021 sync_i=1: phase <= 0 and shadows load, whether or not a step occurs; if simultaneous with a step, data_o uses the pre-sync phase and the increment is discarded.
REQ-022 freq_i=0: output constant at shape(u); shadows load only via sync_i or en_i=0.
REQ-023 No combinational path from any input to valid_o or data_o.

Reset
REQ-024 While reset_ni=0: phase=0, valid_o=0, data_o=0, mode shadow=OFF, duty shadow=0.
REQ-025 Reset asserted mid-stall SHALL discard the held sample immediately; no sample emitted after release until the REQ-014 step condition holds.

Structure
REQ-026 Package wave_pkg SHALL hold wave_mode_t (SAW, TRI, SQR, OFF; 2-bit) and mode encodings.
REQ-027 Combinational sub-module wave_shaper (u, mode, duty -> sample) SHALL implement REQ-018; wave_nco holds accumulator, shadows, output register.
REQ-028 Target 120-400 RTL lines; no ROM, no multipliers.

Verification (width_p=8, phase_width_p=10)
REQ-029 freq=4, SAW, en=1, ready=1 -> data 0,1,2,...,255,0 on successive cycles; valid high from first cycle after en.
REQ-030 freq=4, TRI -> 0,2,...,254 (u=0..127), then 254,252,...,0 (u=128..255), repeat; period 256 samples.
REQ-031 freq=4, SQR, duty=64 -> 64 samples of 255, then 192 samples of 0; duty_i changed to 128 mid-period -> new duty visible only after wrap.
REQ-032 SAW, ready_i low 5 cycles at data=10 -> data_o=10, valid_o=1 held 5 cycles; on ready high data continues 11,12 (no skip, no repeat).
REQ-033 sync_i pulse at data=100 with ready=1 -> next sample 100's successor discarded, following sample 0; mode_i change during same cycle applied immediately.
REQ-034 reset_ni low at data=50 mid-stall -> valid_o, data_o 0 asynchronously; after release with en=1, first sample 0.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared types for the wave NCO: waveform select encoding.
package wave_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW = 2'd0,
    WAVE_TRI = 2'd1,
    WAVE_SQR = 2'd2,
    WAVE_OFF = 2'd3
  } wave_mode_t;

  localparam logic [1:0] MODE_SAW = 2'd0;
  localparam logic [1:0] MODE_TRI = 2'd1;
  localparam logic [1:0] MODE_SQR = 2'd2;
  localparam logic [1:0] MODE_OFF = 2'd3;

endpackage

// File: rtl/wave_nco_if.sv
// Control and sample-stream bundle for wave_nco; master is the generator side.
interface wave_nco_if
  import wave_pkg::*;
#(
  parameter int width_p       = 12,
  parameter int phase_width_p = 24
);
  logic                     en_i;
  logic [phase_width_p-1:0] freq_i;
  wave_mode_t               mode_i;
  logic [width_p-1:0]       duty_i;
  logic                     sync_i;
  logic                     ready_i;
  logic                     valid_o;
  logic [width_p-1:0]       data_o;

  modport master (
    input  en_i, freq_i, mode_i, duty_i, sync_i, ready_i,
    output valid_o, data_o
  );

  modport slave (
    output en_i, freq_i, mode_i, duty_i, sync_i, ready_i,
    input  valid_o, data_o
  );
endinterface

// File: rtl/wave_shaper.sv
// Combinational phase-to-amplitude map: saw, triangle, square, off.
module wave_shaper
  import wave_pkg::*;
#(
  parameter int width_p = 12
) (
  input  logic [width_p-1:0] u,
  input  wave_mode_t         mode,
  input  logic [width_p-1:0] duty,
  output logic [width_p-1:0] sample
);

  logic [width_p-1:0] tri_fold;

  // Second half of the cycle mirrors the first so the doubled value ramps back down.
  assign tri_fold = u[width_p-1] ? ~u : u;

  always_comb begin
    sample = '0;
    case (mode)
      WAVE_SAW: sample = u;
      WAVE_TRI: sample = {tri_fold[width_p-2:0], 1'b0};
      WAVE_SQR: sample = (u < duty) ? '1 : '0;
      default:  sample = '0;
    endcase
  end

endmodule

// File: rtl/wave_nco.sv
// Phase-accumulator NCO with shadowed mode/duty and a registered valid/ready output.
module wave_nco
  import wave_pkg::*;
#(
  parameter int width_p       = 12,
  parameter int phase_width_p = 24
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  wave_nco_if.master bus
);

  logic [phase_width_p-1:0] phase_q;
  logic [phase_width_p:0]   phase_sum;
  logic [width_p-1:0]       u;
  logic [width_p-1:0]       sample;
  logic [width_p-1:0]       duty_q;
  logic [width_p-1:0]       data_q;
  wave_mode_t               mode_q;
  logic                     valid_q;
  logic                     step;
  logic                     shadow_load;

  assign u           = phase_q[phase_width_p-1 -: width_p];
  assign step        = bus.en_i && (!valid_q || bus.ready_i);
  assign phase_sum   = {1'b0, phase_q} + {1'b0, bus.freq_i};
  // Shadows only change at a period boundary, on sync, or while idle, so a
  // waveform never switches shape mid-period.
  assign shadow_load = (step && phase_sum[phase_width_p]) || bus.sync_i || !bus.en_i;

  wave_shaper #(.width_p(width_p)) u_shaper (
    .u      (u),
    .mode   (mode_q),
    .duty   (duty_q),
    .sample (sample)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      mode_q  <= WAVE_OFF;
      duty_q  <= '0;
    end else begin
      if (step) begin
        data_q  <= sample;
        valid_q <= 1'b1;
      end else if (!bus.en_i && bus.ready_i && valid_q) begin
        valid_q <= 1'b0;
      end

      if (bus.sync_i) begin
        phase_q <= '0;
      end else if (step) begin
        phase_q <= phase_sum[phase_width_p-1:0];
      end

      if (shadow_load) begin
        mode_q <= bus.mode_i;
        duty_q <= bus.duty_i;
      end
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;

endmodule

// File: tb/tb_wave_nco.sv
// Directed bench for wave_nco at width 8, phase width 10 (one u step per sample at freq 4).
module tb_wave_nco;
  import wave_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   passes = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  wave_nco_if #(.width_p(8), .phase_width_p(10)) bus ();

  wave_nco #(.width_p(8), .phase_width_p(10)) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Idle one edge with sync to zero the phase and load the shadows, then enable.
  task automatic restart(input wave_mode_t m, input logic [7:0] d);
    bus.en_i   = 1'b0;
    bus.sync_i = 1'b1;
    bus.mode_i = m;
    bus.duty_i = d;
    tick();
    bus.sync_i = 1'b0;
    bus.en_i   = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.en_i    = 1'b0;
    bus.freq_i  = 10'd4;
    bus.mode_i  = WAVE_SAW;
    bus.duty_i  = 8'd0;
    bus.sync_i  = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    tick();
    check("reset_valid", 32'(bus.valid_o), 32'd0);
    check("reset_data", 32'(bus.data_o), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_valid", 32'(bus.valid_o), 32'd0);

    // Sawtooth: full period plus wrap back to 0.
    restart(WAVE_SAW, 8'd0);
    for (int k = 0; k <= 256; k++) begin
      tick();
      if (k == 0) check("saw_first_valid", 32'(bus.valid_o), 32'd1);
      check("saw", 32'(bus.data_o), 32'(k % 256));
    end

    // Triangle: up in steps of 2, then back down.
    restart(WAVE_TRI, 8'd0);
    for (int k = 0; k < 256; k++) begin
      tick();
      check("tri", 32'(bus.data_o), (k < 128) ? 32'(2 * k) : 32'(2 * (255 - k)));
    end

    // Square: duty changes mid-period, takes effect only after the wrap.
    restart(WAVE_SQR, 8'd64);
    for (int k = 0; k < 512; k++) begin
      tick();
      if (k == 100) bus.duty_i = 8'd128;
      if (k < 256) check("sqr_duty64", 32'(bus.data_o), (k < 64) ? 32'd255 : 32'd0);
      else check("sqr_duty128", 32'(bus.data_o), ((k - 256) < 128) ? 32'd255 : 32'd0);
    end

    // Backpressure: hold 10 for five stalled cycles, then resume without skip.
    restart(WAVE_SAW, 8'd0);
    repeat (11) tick();
    check("stall_pre", 32'(bus.data_o), 32'd10);
    bus.ready_i = 1'b0;
    repeat (5) begin
      tick();
      check("stall_data", 32'(bus.data_o), 32'd10);
      check("stall_valid", 32'(bus.valid_o), 32'd1);
    end
    bus.ready_i = 1'b1;
    tick();
    check("resume_11", 32'(bus.data_o), 32'd11);
    tick();
    check("resume_12", 32'(bus.data_o), 32'd12);

    // Sync at 100 with a mode change: pre-sync sample goes out, then TRI from phase 0.
    restart(WAVE_SAW, 8'd0);
    repeat (101) tick();
    check("sync_pre", 32'(bus.data_o), 32'd100);
    bus.sync_i = 1'b1;
    bus.mode_i = WAVE_TRI;
    tick();
    check("sync_edge", 32'(bus.data_o), 32'd101);
    bus.sync_i = 1'b0;
    tick();
    check("sync_zero", 32'(bus.data_o), 32'd0);
    tick();
    check("sync_tri1", 32'(bus.data_o), 32'd2);
    tick();
    check("sync_tri2", 32'(bus.data_o), 32'd4);

    // Disable with ready: valid drops, data held.
    bus.en_i = 1'b0;
    tick();
    check("dis_valid", 32'(bus.valid_o), 32'd0);
    check("dis_data", 32'(bus.data_o), 32'd4);

    // Zero frequency: constant output, mode_i change not applied without a wrap.
    bus.freq_i = 10'd0;
    restart(WAVE_SQR, 8'd200);
    repeat (3) begin
      tick();
      check("freq0_const", 32'(bus.data_o), 32'd255);
    end
    bus.mode_i = WAVE_SAW;
    tick();
    check("freq0_noload", 32'(bus.data_o), 32'd255);

    // Reset during a stall clears the held sample immediately.
    bus.freq_i = 10'd4;
    restart(WAVE_SAW, 8'd0);
    repeat (51) tick();
    check("rst_pre", 32'(bus.data_o), 32'd50);
    bus.ready_i = 1'b0;
    tick();
    check("rst_stall", 32'(bus.data_o), 32'd50);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(bus.valid_o), 32'd0);
    check("rst_async_data", 32'(bus.data_o), 32'd0);
    tick();
    reset_n     = 1'b1;
    bus.ready_i = 1'b1;
    tick();
    check("rst_first_valid", 32'(bus.valid_o), 32'd1);
    check("rst_first_data", 32'(bus.data_o), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
